// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the five-stage MIPS core, with load-use hazard
//   detection. Decoded control, operands, immediate and register specifiers
//   are captured from Decode and presented to Execute one cycle later.
//   When the load in Execute writes a register that Decode reads, the stage
//   freezes PC and IF/ID for one cycle and loads a bubble into Execute.
//   A taken-branch flush also loads a bubble, and it overrides the freeze.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   id_*                        decoded control bits, ALU op class, operands,
//                               sign-extended immediate, rs/rt/rd
//   flush                       instruction in Decode is wrong-path
//   ex_*                        registered copies of the id_* fields
//   ex_funct / ex_shamt         immediate slices [5:0] / [10:6] for ALU control
//   pc_write / ifid_write       combinational advance enables (0 = freeze)
//   stall_count                 saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_reg_write,
   input  logic              id_mem_to_reg,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic              id_reg_dst,
   input  logic              id_alu_src,
   input  logic [1:0]        id_alu_op,
   input  logic [DATA_W-1:0] id_read_data1,
   input  logic [DATA_W-1:0] id_read_data2,
   input  logic [DATA_W-1:0] id_sign_ext,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              flush,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic              ex_reg_dst,
   output logic              ex_alu_src,
   output logic [1:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_read_data1,
   output logic [DATA_W-1:0] ex_read_data2,
   output logic [DATA_W-1:0] ex_sign_ext,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic [5:0]        ex_funct,
   output logic [4:0]        ex_shamt,
   output logic              pc_write,
   output logic              ifid_write,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

   // Control bundle bit order: {reg_write, mem_to_reg, mem_read, mem_write,
   //                            branch, reg_dst, alu_src}
   localparam int CTL_MEM_READ = 4;

   logic              hazard_s;
   logic              stall_s;
   logic              bubble_s;

   logic [6:0]        ctrl_d,   ctrl_q;
   logic [1:0]        alu_op_d, alu_op_q;
   logic [DATA_W-1:0] rd1_d,    rd1_q;
   logic [DATA_W-1:0] rd2_d,    rd2_q;
   logic [DATA_W-1:0] se_d,     se_q;
   logic [REG_W-1:0]  rs_d,     rs_q;
   logic [REG_W-1:0]  rt_d,     rt_q;
   logic [REG_W-1:0]  rd_d,     rd_q;
   logic [CNT_W-1:0]  cnt_d,    cnt_q;

   // Load-use hazard detection from the registered EX fields and live ID specifiers.
   always_comb begin
      hazard_s = 1'b0;
      stall_s  = 1'b0;
      bubble_s = 1'b0;
      // A load to $0 never produces a usable value, so it never stalls.
      if (ctrl_q[CTL_MEM_READ] && (rt_q != REG_ZERO) &&
          ((rt_q == id_rs) || (rt_q == id_rt))) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
      // A wrong-path instruction is discarded anyway, so flush cancels the freeze.
      stall_s  = hazard_s & ~flush;
      bubble_s = stall_s | flush;
   end

   // Next-state selection for the pipeline register and stall counter.
   always_comb begin
      rd1_d = id_read_data1;
      rd2_d = id_read_data2;
      se_d  = id_sign_ext;
      rs_d  = id_rs;
      rt_d  = id_rt;
      rd_d  = id_rd;
      if (bubble_s) begin
         // alu_op 00 makes ALU control pick add; harmless since nothing writes.
         ctrl_d   = 7'b000_0000;
         alu_op_d = 2'b00;
      end else begin
         ctrl_d   = {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
                     id_branch, id_reg_dst, id_alu_src};
         alu_op_d = id_alu_op;
      end
      if (stall_s && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pipeline register and counter update; reset overrides stall and flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q   <= 7'b000_0000;
         alu_op_q <= 2'b00;
         rd1_q    <= {DATA_W{1'b0}};
         rd2_q    <= {DATA_W{1'b0}};
         se_q     <= {DATA_W{1'b0}};
         rs_q     <= REG_ZERO;
         rt_q     <= REG_ZERO;
         rd_q     <= REG_ZERO;
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         ctrl_q   <= ctrl_d;
         alu_op_q <= alu_op_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         se_q     <= se_d;
         rs_q     <= rs_d;
         rt_q     <= rt_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
      end
   end

   assign {ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_branch, ex_reg_dst, ex_alu_src} = ctrl_q;
   assign ex_alu_op     = alu_op_q;
   assign ex_read_data1 = rd1_q;
   assign ex_read_data2 = rd2_q;
   assign ex_sign_ext   = se_q;
   assign ex_rs         = rs_q;
   assign ex_rt         = rt_q;
   assign ex_rd         = rd_q;
   assign ex_funct      = se_q[5:0];
   assign ex_shamt      = se_q[10:6];
   // Enables must act in the hazard cycle itself, so they are not registered.
   assign pc_write      = ~stall_s;
   assign ifid_write    = ~stall_s;
   assign stall_count   = cnt_q;

endmodule
